fp_mul_pipe_mf: RTL and testbench
=================================

Name: fp_mul_pipe_mf

Overview:
- Pipelined, multi-format, SIMD floating-point multiplier. Successor to the combinational 32-bit packed multiplier.
- Processes NUM_WORDS packed 32-bit words per transaction, with a valid/ready handshake and stall-capable pipeline.
- Format is selected per transaction; the config travels down the pipeline with its data.
- Adds zero handling, overflow/underflow saturation with per-lane flags, and optional RNE rounding. Sits between operand buffers and the fused accumulate stage.

Parameters:
- NUM_WORDS, 1, number of independent packed 32-bit words multiplied per transaction (1..8).
- PIPE_STAGES, 3, register stages from input accept to output valid (2..6).

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand transaction valid.
- IN_READY  output  1  block can accept a transaction this cycle.
- IN1  input  32*NUM_WORDS  packed operand A; word w at [32w+31:32w].
- IN2  input  32*NUM_WORDS  packed operand B.
- CONFIG_FP  input  CONFIG_WIDTH  format code (CONFIG_FP32/TF32/FP16/BF16/FP8_E4M3/FP8_E5M2, from define.sv), sampled with IN_VALID.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- OUT  output  32*NUM_WORDS  packed products, same lane layout as inputs.
- OUT_CONFIG  output  CONFIG_WIDTH  format code of the current OUT.
- OUT_OVF  output  4*NUM_WORDS  per-lane overflow flag.
- OUT_UDF  output  4*NUM_WORDS  per-lane underflow flag.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Lanes per word:
  - FP32: lane0 = [31:0].
  - TF32: left-aligned in [31:13], lane0; result [12:0] = 0.
  - FP16/BF16: lane0 = [15:0], lane1 = [31:16].
  - FP8: lane k = byte k.
  - Flag bits for unused lanes are 0.
- Per-lane arithmetic:
  - sign = s1 ^ s2.
  - Unbiased exp sum computed at width E+2 (signed), so there is no wrap.
  - Mantissa product of implicit-1 significands; normalise by at most 1 bit.
- Zero/subnormal input (exp field == 0): treated as zero; output is signed zero, flags 0.
- Overflow (biased exp > max normal): OVF=1.
  - Output ±Inf (exp all-ones, mantissa 0) for FP32/TF32/FP16/BF16/E5M2.
  - E4M3 saturates to S.1111.110 (±448).
- Underflow (biased exp < 1 after rounding): UDF=1; flush to signed zero.
- Inf/NaN inputs are not specially decoded (exp all-ones is processed numerically); unchanged from the current block.
- Unknown CONFIG_FP: output 0, flags 0; the transaction still completes the handshake.
- Pipeline:
  - PIPE_STAGES stages, each with a valid bit.
  - Stage s advances when it is empty or stage s+1 advances.
  - The last stage advances when OUT_READY or when it is empty.
  - IN_READY = !valid[0] || advance[0] (combinational from OUT_READY is permitted).
- Throughput and latency:
  - Full throughput: 1 transaction/cycle when OUT_READY=1.
  - Latency = PIPE_STAGES cycles, from the accepting edge to OUT_VALID high, with no stall.
- Stall: OUT, OUT_CONFIG and flags are held stable while OUT_VALID && !OUT_READY. No drop, no duplicate, order preserved.
- Full: when all stages are valid and OUT_READY=0, IN_READY=0. Simultaneous accept and output in the same cycle is legal when full and OUT_READY=1.
- Reset:
  - All valid bits, OUT_VALID, OUT, OUT_CONFIG, OUT_OVF and OUT_UDF are 0.
  - IN_READY=1 the cycle after RST deasserts.
  - Reset mid-operation discards all in-flight transactions.

Optional Feature:
- Macro: FPMUL_PIPE_RNE_EN.
- Defined: round-to-nearest-even on the mantissa product (guard/round/sticky). Rounding carry renormalises the exponent; overflow is checked after rounding.
- Undefined: truncation, which is bit-compatible with the existing combinational multiplier on in-range results.
- Latency is identical in both builds.

Test Plan:
- FP32, NUM_WORDS=1, PIPE_STAGES=3: IN1=0x3FC00000, IN2=0x40000000 -> OUT=0x40400000, OUT_VALID exactly 3 cycles after accept, flags 0.
- FP16: IN1=0x3C004000, IN2=0x42003800 -> OUT=0x42003C00.
- FP32 special cases:
  - 0x7F000000*0x7F000000 -> 0x7F800000, OUT_OVF[0]=1.
  - 0x80000000*0x3F800000 -> 0x80000000, flags 0.
- E4M3: IN1=0x77383838, IN2=0x48383838 -> OUT=0x7E383838, OUT_OVF=4'b1000.
- Rounding: FP32 0x3F800001*0x3FC00000 -> 0x3FC00002 with FPMUL_PIPE_RNE_EN (tie to even); 0x3FC00001 without.
- Backpressure and reset:
  - Issue 6 back-to-back transactions; hold OUT_READY=0 for 5 cycles -> IN_READY falls after 3 accepts, OUT held stable, all 6 results emerge in order.
  - RST mid-stream -> OUT_VALID=0 next cycle, no stale results afterward.

Source files
------------

// File: rtl/fp_mul_pipe_mf.sv
// Pipelined SIMD multi-format FP multiplier (FP32/TF32/FP16/BF16/E4M3/E5M2) with valid/ready stall.
// Build option: define FPMUL_PIPE_RNE_EN for round-to-nearest-even, otherwise the mantissa is truncated.

module fp_mul_lane #(
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int MAX_EXP    = (1 << E) - 2,
  parameter bit SAT_FINITE = 1'b0
) (
  input  logic [E+M:0] i_a,
  input  logic [E+M:0] i_b,
  output logic [E+M:0] o_p,
  output logic         o_ovf,
  output logic         o_udf
);
  localparam int EW = E + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (E - 1)) - 1);
  localparam logic signed [EW-1:0] MAXE = EW'(MAX_EXP);
  localparam logic signed [EW-1:0] ONE  = EW'(1);

  logic [2*M+1:0]       w_pa, w_pb;
  logic                 w_hi, w_rnd, w_sign, w_zero;
  logic [M-1:0]         w_mant;
  logic [M:0]           w_mant_r;
  logic signed [EW-1:0] w_exp, w_exp_f;

  assign w_pa   = {{(M+1){1'b0}}, 1'b1, i_a[M-1:0]};
  assign w_pb   = {{(M+1){1'b0}}, 1'b1, i_b[M-1:0]};
  assign w_sign = i_a[E+M] ^ i_b[E+M];
  assign w_zero = (i_a[E+M-1:M] == '0) || (i_b[E+M-1:M] == '0);

`ifdef FPMUL_PIPE_RNE_EN
  logic [2*M+1:0] w_prod;
  assign w_prod = w_pa * w_pb;
  assign w_hi   = w_prod[2*M+1];
  assign w_mant = w_hi ? w_prod[2*M:M+1] : w_prod[2*M-1:M];
  assign w_rnd  = (w_hi ? w_prod[M] : w_prod[M-1]) &
                  ((w_hi ? |w_prod[M-1:0] : |w_prod[M-2:0]) | w_mant[0]);
`else
  // Only the upper half of the product matters when truncating.
  logic [M+1:0] w_ph;
  assign w_ph   = (M+2)'((w_pa * w_pb) >> M);
  assign w_hi   = w_ph[M+1];
  assign w_mant = w_hi ? w_ph[M:1] : w_ph[M-1:0];
  assign w_rnd  = 1'b0;
`endif

  assign w_exp    = EW'(i_a[E+M-1:M]) + EW'(i_b[E+M-1:M]) - BIAS + EW'(w_hi);
  assign w_mant_r = {1'b0, w_mant} + (M+1)'(w_rnd);
  assign w_exp_f  = w_exp + EW'(w_mant_r[M]);

  always_comb begin
    o_p   = {w_sign, w_exp_f[E-1:0], w_mant_r[M-1:0]};
    o_ovf = 1'b0;
    o_udf = 1'b0;
    if (w_zero) begin
      o_p = {w_sign, {(E+M){1'b0}}};
    end else if (w_exp_f > MAXE) begin
      o_ovf = 1'b1;
      o_p   = SAT_FINITE ? {w_sign, {E{1'b1}}, {(M-1){1'b1}}, 1'b0}
                         : {w_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (w_exp_f < ONE) begin
      o_udf = 1'b1;
      o_p   = {w_sign, {(E+M){1'b0}}};
    end
  end
endmodule

module fp_mul_pipe_mf #(
  parameter int NUM_WORDS    = 1,
  parameter int PIPE_STAGES  = 3,
  parameter int CONFIG_WIDTH = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [32*NUM_WORDS-1:0]   IN1,
  input  logic [32*NUM_WORDS-1:0]   IN2,
  input  logic [CONFIG_WIDTH-1:0]   CONFIG_FP,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [32*NUM_WORDS-1:0]   OUT,
  output logic [CONFIG_WIDTH-1:0]   OUT_CONFIG,
  output logic [4*NUM_WORDS-1:0]    OUT_OVF,
  output logic [4*NUM_WORDS-1:0]    OUT_UDF
);
  localparam logic [CONFIG_WIDTH-1:0] CONFIG_FP32     = CONFIG_WIDTH'(0);
  localparam logic [CONFIG_WIDTH-1:0] CONFIG_TF32     = CONFIG_WIDTH'(1);
  localparam logic [CONFIG_WIDTH-1:0] CONFIG_FP16     = CONFIG_WIDTH'(2);
  localparam logic [CONFIG_WIDTH-1:0] CONFIG_BF16     = CONFIG_WIDTH'(3);
  localparam logic [CONFIG_WIDTH-1:0] CONFIG_FP8_E4M3 = CONFIG_WIDTH'(4);
  localparam logic [CONFIG_WIDTH-1:0] CONFIG_FP8_E5M2 = CONFIG_WIDTH'(5);
  localparam int DW = 32 * NUM_WORDS;
  localparam int FW = 4 * NUM_WORDS;

  logic [PIPE_STAGES-1:0]  r_vld;
  wire  [PIPE_STAGES-1:0]  w_adv;
  logic [DW-1:0]           r_a, r_b;
  logic [CONFIG_WIDTH-1:0] r_cfg0;
  logic [DW-1:0]           r_out [PIPE_STAGES-1:1];
  logic [CONFIG_WIDTH-1:0] r_cfg [PIPE_STAGES-1:1];
  logic [FW-1:0]           r_ovf [PIPE_STAGES-1:1];
  logic [FW-1:0]           r_udf [PIPE_STAGES-1:1];
  wire  [DW-1:0]           w_res;
  wire  [FW-1:0]           w_ovf, w_udf;

  // A stage moves if any stage at or after it has a hole, or the sink takes the head.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_adv
    assign w_adv[s] = OUT_READY || !(&r_vld[PIPE_STAGES-1:s]);
  end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    logic [31:0] w_a, w_b, w_p;
    logic [3:0]  w_o, w_u;
    wire  [31:0] w_p32;
    wire  [18:0] w_ptf;
    wire  [15:0] w_p16 [2];
    wire  [15:0] w_pbf [2];
    wire  [7:0]  w_pe4 [4];
    wire  [7:0]  w_pe5 [4];
    wire         w_o32, w_u32, w_otf, w_utf;
    wire  [1:0]  w_o16, w_u16, w_obf, w_ubf;
    wire  [3:0]  w_oe4, w_ue4, w_oe5, w_ue5;

    assign w_a = r_a[32*w +: 32];
    assign w_b = r_b[32*w +: 32];

    fp_mul_lane #(.E(8), .M(23)) u_fp32 (
      .i_a(w_a), .i_b(w_b), .o_p(w_p32), .o_ovf(w_o32), .o_udf(w_u32));
    fp_mul_lane #(.E(8), .M(10)) u_tf32 (
      .i_a(w_a[31:13]), .i_b(w_b[31:13]), .o_p(w_ptf), .o_ovf(w_otf), .o_udf(w_utf));

    for (genvar k = 0; k < 2; k++) begin : g_half
      fp_mul_lane #(.E(5), .M(10)) u_fp16 (
        .i_a(w_a[16*k +: 16]), .i_b(w_b[16*k +: 16]),
        .o_p(w_p16[k]), .o_ovf(w_o16[k]), .o_udf(w_u16[k]));
      fp_mul_lane #(.E(8), .M(7)) u_bf16 (
        .i_a(w_a[16*k +: 16]), .i_b(w_b[16*k +: 16]),
        .o_p(w_pbf[k]), .o_ovf(w_obf[k]), .o_udf(w_ubf[k]));
    end

    for (genvar k = 0; k < 4; k++) begin : g_byte
      // E4M3 has no infinity; the top exponent code is a normal binade.
      fp_mul_lane #(.E(4), .M(3), .MAX_EXP(15), .SAT_FINITE(1'b1)) u_e4m3 (
        .i_a(w_a[8*k +: 8]), .i_b(w_b[8*k +: 8]),
        .o_p(w_pe4[k]), .o_ovf(w_oe4[k]), .o_udf(w_ue4[k]));
      fp_mul_lane #(.E(5), .M(2)) u_e5m2 (
        .i_a(w_a[8*k +: 8]), .i_b(w_b[8*k +: 8]),
        .o_p(w_pe5[k]), .o_ovf(w_oe5[k]), .o_udf(w_ue5[k]));
    end

    always_comb begin
      w_p = '0;
      w_o = '0;
      w_u = '0;
      case (r_cfg0)
        CONFIG_FP32:     begin w_p = w_p32; w_o = {3'b0, w_o32}; w_u = {3'b0, w_u32}; end
        CONFIG_TF32:     begin w_p = {w_ptf, 13'b0}; w_o = {3'b0, w_otf}; w_u = {3'b0, w_utf}; end
        CONFIG_FP16:     begin w_p = {w_p16[1], w_p16[0]}; w_o = {2'b0, w_o16}; w_u = {2'b0, w_u16}; end
        CONFIG_BF16:     begin w_p = {w_pbf[1], w_pbf[0]}; w_o = {2'b0, w_obf}; w_u = {2'b0, w_ubf}; end
        CONFIG_FP8_E4M3: begin w_p = {w_pe4[3], w_pe4[2], w_pe4[1], w_pe4[0]}; w_o = w_oe4; w_u = w_ue4; end
        CONFIG_FP8_E5M2: begin w_p = {w_pe5[3], w_pe5[2], w_pe5[1], w_pe5[0]}; w_o = w_oe5; w_u = w_ue5; end
        default: ;
      endcase
    end

    assign w_res[32*w +: 32] = w_p;
    assign w_ovf[4*w +: 4]   = w_o;
    assign w_udf[4*w +: 4]   = w_u;
  end

  // Stage 0 holds operands; arithmetic sits between stage 0 and stage 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cfg0 <= '0;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_out[s] <= '0;
        r_cfg[s] <= '0;
        r_ovf[s] <= '0;
        r_udf[s] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= IN_VALID;
        if (IN_VALID) begin
          r_a    <= IN1;
          r_b    <= IN2;
          r_cfg0 <= CONFIG_FP;
        end
      end
      if (w_adv[1]) begin
        r_vld[1] <= r_vld[0];
        if (r_vld[0]) begin
          r_out[1] <= w_res;
          r_cfg[1] <= r_cfg0;
          r_ovf[1] <= w_ovf;
          r_udf[1] <= w_udf;
        end
      end
      for (int s = 2; s < PIPE_STAGES; s++) begin
        if (w_adv[s]) begin
          r_vld[s] <= r_vld[s-1];
          if (r_vld[s-1]) begin
            r_out[s] <= r_out[s-1];
            r_cfg[s] <= r_cfg[s-1];
            r_ovf[s] <= r_ovf[s-1];
            r_udf[s] <= r_udf[s-1];
          end
        end
      end
    end
  end

  assign IN_READY   = w_adv[0];
  assign OUT_VALID  = r_vld[PIPE_STAGES-1];
  assign OUT        = r_out[PIPE_STAGES-1];
  assign OUT_CONFIG = r_cfg[PIPE_STAGES-1];
  assign OUT_OVF    = r_ovf[PIPE_STAGES-1];
  assign OUT_UDF    = r_udf[PIPE_STAGES-1];
endmodule

// File: tb/tb_fp_mul_pipe_mf.sv
// Directed bench for fp_mul_pipe_mf: vector table plus backpressure and mid-stream reset sequences.
module tb_fp_mul_pipe_mf;
  localparam int NW = 1;
  localparam int PS = 3;
  localparam int CW = 3;
  localparam logic [2:0] C_FP32 = 3'd0;
  localparam logic [2:0] C_TF32 = 3'd1;
  localparam logic [2:0] C_FP16 = 3'd2;
  localparam logic [2:0] C_BF16 = 3'd3;
  localparam logic [2:0] C_E4M3 = 3'd4;
  localparam logic [2:0] C_E5M2 = 3'd5;
  localparam logic [2:0] C_BAD  = 3'd7;
`ifdef FPMUL_PIPE_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h3FC00002;
`else
  localparam logic [31:0] RND_EXP = 32'h3FC00001;
`endif

  typedef struct packed {
    logic [2:0]  cfg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [3:0]  ovf;
    logic [3:0]  udf;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [31:0]   IN1, IN2, OUT;
  logic [CW-1:0] CONFIG_FP, OUT_CONFIG;
  logic [3:0]    OUT_OVF, OUT_UDF;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [14];

  always #5 CLK = ~CLK;

  fp_mul_pipe_mf #(.NUM_WORDS(NW), .PIPE_STAGES(PS), .CONFIG_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN1(IN1), .IN2(IN2), .CONFIG_FP(CONFIG_FP), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT(OUT), .OUT_CONFIG(OUT_CONFIG),
    .OUT_OVF(OUT_OVF), .OUT_UDF(OUT_UDF));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    @(negedge CLK);
    IN1 = v.a; IN2 = v.b; CONFIG_FP = v.cfg; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1 check($sformatf("v%0d in_ready", idx), 32'(IN_READY), 32'd1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check($sformatf("v%0d latency", idx), 32'(n), 32'(PS));
    check($sformatf("v%0d out", idx), OUT, v.out);
    check($sformatf("v%0d cfg", idx), 32'(OUT_CONFIG), 32'(v.cfg));
    check($sformatf("v%0d ovf", idx), 32'(OUT_OVF), 32'(v.ovf));
    check($sformatf("v%0d udf", idx), 32'(OUT_UDF), 32'(v.udf));
  endtask

  task automatic backpressure();
    logic [31:0] exp_q [6];
    int acc = 0, got = 0, acc_at_full = -1;
    logic dup = 1'b0;
    for (int k = 0; k < 6; k++) exp_q[k] = 32'h40100000 + 32'(k) * 32'h00010000;
    CONFIG_FP = C_FP32;
    IN2 = 32'h3F800000;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge CLK);
      OUT_READY = (cyc >= 5);
      IN_VALID  = (acc < 6);
      IN1       = (acc < 6) ? exp_q[acc] : 32'h0;
      #1;
      if (!IN_READY && acc_at_full < 0) acc_at_full = acc;
      if (OUT_VALID) begin
        check($sformatf("bp out%0d", got), OUT, exp_q[got]);
        if (OUT_READY) got++;
      end
      if (IN_VALID && IN_READY) acc++;
    end
    @(negedge CLK);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    check("bp accepts before full", 32'(acc_at_full), 32'd3);
    check("bp result count", 32'(got), 32'd6);
    repeat (5) begin
      @(negedge CLK);
      if (OUT_VALID) dup = 1'b1;
    end
    check("bp no duplicate", 32'(dup), 32'd0);
  endtask

  task automatic reset_midstream();
    logic stale = 1'b0;
    @(negedge CLK);
    OUT_READY = 1'b0; IN_VALID = 1'b1; CONFIG_FP = C_FP32;
    IN1 = 32'h7F000000; IN2 = 32'h7F000000;
    repeat (3) @(negedge CLK);
    IN_VALID = 1'b0;
    check("rst pre out_valid", 32'(OUT_VALID), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("rst out_valid", 32'(OUT_VALID), 32'd0);
    check("rst out", OUT, 32'h0);
    check("rst ovf", 32'(OUT_OVF), 32'd0);
    RST = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("rst in_ready", 32'(IN_READY), 32'd1);
    repeat (6) begin
      @(negedge CLK);
      if (OUT_VALID) stale = 1'b1;
    end
    check("rst no stale", 32'(stale), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN1 = '0; IN2 = '0; CONFIG_FP = '0;
    vecs[0]  = '{C_FP32, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, 4'h0};
    vecs[1]  = '{C_FP16, 32'h3C004000, 32'h42003800, 32'h42003C00, 4'h0, 4'h0};
    vecs[2]  = '{C_FP32, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h1, 4'h0};
    vecs[3]  = '{C_FP32, 32'h80000000, 32'h3F800000, 32'h80000000, 4'h0, 4'h0};
    vecs[4]  = '{C_E4M3, 32'h77383838, 32'h48383838, 32'h7E383838, 4'h8, 4'h0};
    vecs[5]  = '{C_FP32, 32'h3F800001, 32'h3FC00000, RND_EXP,      4'h0, 4'h0};
    vecs[6]  = '{C_FP32, 32'h00800000, 32'h3F000000, 32'h00000000, 4'h0, 4'h1};
    vecs[7]  = '{C_FP32, 32'h80800000, 32'h3F000000, 32'h80000000, 4'h0, 4'h1};
    vecs[8]  = '{C_BF16, 32'hC0003FC0, 32'h3F804000, 32'hC0004040, 4'h0, 4'h0};
    vecs[9]  = '{C_TF32, 32'h3FC01FFF, 32'h40001234, 32'h40400000, 4'h0, 4'h0};
    vecs[10] = '{C_E5M2, 32'h7B3E0004, 32'h4040BC38, 32'h7C428000, 4'h8, 4'h1};
    vecs[11] = '{C_FP16, 32'hBC007800, 32'h3C007800, 32'hBC007C00, 4'h1, 4'h0};
    vecs[12] = '{C_BAD,  32'h3FC00000, 32'h40000000, 32'h00000000, 4'h0, 4'h0};
    vecs[13] = '{C_FP32, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'h0, 4'h0};

    repeat (3) @(negedge CLK);
    check("reset out_valid", 32'(OUT_VALID), 32'd0);
    check("reset out", OUT, 32'h0);
    check("reset out_config", 32'(OUT_CONFIG), 32'd0);
    check("reset flags", 32'({OUT_OVF, OUT_UDF}), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("reset in_ready", 32'(IN_READY), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(i);
    backpressure();
    reset_midstream();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
